board_mem_arbiter: RTL and testbench

Arbitrates one single-port synchronous board RAM (1-cycle read latency) among three requesters: the cpu data port, the video scanner that reads the minesweeper board, and the keypad/input writer. The cpu has fixed priority, bounded by a starvation guard. Video and keypad share round-robin priority. It sits between the cpu's Din/MW data interface and the board RAM, and drives CPU_STALL, which gates the cpu clock enable.

---
 rtl/board_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_board_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: cpu data port (fixed priority with a starvation guard),
// video scanner and keypad writer (round-robin between themselves). 1-cycle RAM read latency.
module board_mem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic [DW-1:0] CPU_RDATA,
  output logic          CPU_STALL,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_ADDR,
  output logic          VID_GNT,
  output logic          VID_VALID,
  output logic [DW-1:0] VID_RDATA,
  input  logic          KEY_REQ,
  input  logic          KEY_WE,
  input  logic [AW-1:0] KEY_ADDR,
  input  logic [DW-1:0] KEY_WDATA,
  output logic          KEY_GNT,
  output logic          KEY_VALID,
  output logic [DW-1:0] KEY_RDATA,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_WDATA,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_RDATA
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {C_IDLE, C_RDWAIT} cpuState_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VID, TAG_KEY} retTag_t;
  typedef enum logic {RR_VID, RR_KEY} rrPtr_t;

  cpuState_t      state, stateNext;
  retTag_t        retTag, retTagNext;
  rrPtr_t         rrPtr, rrPtrNext;
  logic [CW-1:0]  starveCnt, starveCntNext;
  logic           starveMask;
  logic           cpuElig;
  logic           cpuGnt, vidGnt, keyGnt;

  assign starveMask = (starveCnt == CW'(STARVE_LIMIT));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= C_IDLE;
      retTag    <= TAG_NONE;
      rrPtr     <= RR_VID;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      retTag    <= retTagNext;
      rrPtr     <= rrPtrNext;
      starveCnt <= starveCntNext;
    end
  end

  // Everything is forced to its idle value while RESET is high, including returns in flight.
  always_comb begin
    cpuElig       = 1'b0;
    cpuGnt        = 1'b0;
    vidGnt        = 1'b0;
    keyGnt        = 1'b0;
    RAM_ADDR      = '0;
    RAM_WDATA     = '0;
    RAM_WE        = 1'b0;
    CPU_STALL     = 1'b0;
    CPU_RDATA     = '0;
    VID_GNT       = 1'b0;
    VID_VALID     = 1'b0;
    VID_RDATA     = '0;
    KEY_GNT       = 1'b0;
    KEY_VALID     = 1'b0;
    KEY_RDATA     = '0;
    stateNext     = C_IDLE;
    retTagNext    = TAG_NONE;
    rrPtrNext     = rrPtr;
    starveCntNext = starveCnt;

    if (!RESET) begin
      cpuElig = CPU_REQ && (state == C_IDLE) && !starveMask;

      if (cpuElig) begin
        cpuGnt = 1'b1;
      end else if (VID_REQ && (!KEY_REQ || rrPtr == RR_VID)) begin
        vidGnt = 1'b1;
      end else if (KEY_REQ) begin
        keyGnt = 1'b1;
      end

      if (cpuGnt) begin
        RAM_ADDR  = CPU_ADDR;
        RAM_WE    = CPU_WE;
        RAM_WDATA = CPU_WE ? CPU_WDATA : '0;
      end else if (vidGnt) begin
        RAM_ADDR  = VID_ADDR;
      end else if (keyGnt) begin
        RAM_ADDR  = KEY_ADDR;
        RAM_WE    = KEY_WE;
        RAM_WDATA = KEY_WE ? KEY_WDATA : '0;
      end

      VID_GNT   = vidGnt;
      KEY_GNT   = keyGnt;
      CPU_STALL = CPU_REQ && (state == C_IDLE) && !(cpuGnt && CPU_WE);

      // The tag says whose read was issued last cycle, so only that port sees RAM_RDATA.
      case (retTag)
        TAG_CPU: CPU_RDATA = RAM_RDATA;
        TAG_VID: begin
          VID_VALID = 1'b1;
          VID_RDATA = RAM_RDATA;
        end
        TAG_KEY: begin
          KEY_VALID = 1'b1;
          KEY_RDATA = RAM_RDATA;
        end
        default: ;
      endcase

      if (cpuGnt && !CPU_WE) begin
        stateNext  = C_RDWAIT;
        retTagNext = TAG_CPU;
      end else if (vidGnt) begin
        retTagNext = TAG_VID;
      end else if (keyGnt && !KEY_WE) begin
        retTagNext = TAG_KEY;
      end

      if (vidGnt || keyGnt) begin
        rrPtrNext = (rrPtr == RR_VID) ? RR_KEY : RR_VID;
      end

      if (vidGnt || keyGnt || !(VID_REQ || KEY_REQ)) begin
        starveCntNext = '0;
      end else if (cpuGnt) begin
        starveCntNext = starveCnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Cycle-by-cycle vector bench for board_mem_arbiter with a behavioural board RAM and a
// read-return scoreboard fed from the bench's own shadow copy of the RAM.
module tb_board_mem_arbiter;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_CPU  = 2'd1;
  localparam logic [1:0] G_VID  = 2'd2;
  localparam logic [1:0] G_KEY  = 2'd3;

  typedef struct {
    logic       rst;
    logic       cReq;
    logic       cWe;
    logic [7:0] cAddr;
    logic [7:0] cWd;
    logic       vReq;
    logic [7:0] vAddr;
    logic       kReq;
    logic       kWe;
    logic [7:0] kAddr;
    logic [7:0] kWd;
    logic [1:0] expGnt;
    logic       expStall;
  } vec_t;

  typedef struct {
    logic [1:0] who;
    logic [7:0] data;
  } ret_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       cpuReq, cpuWe, vidReq, keyReq, keyWe;
  logic [7:0] cpuAddr, cpuWdata, vidAddr, keyAddr, keyWdata;
  logic [7:0] cpuRdata, vidRdata, keyRdata;
  logic       cpuStall, vidGnt, vidValid, keyGnt, keyValid;
  logic [7:0] ramAddr, ramWdata, ramRdata;
  logic       ramWe;

  logic [7:0] ramMem [256];
  logic [7:0] refMem [256];
  logic       loaded = 1'b0;

  vec_t vecs[$];
  ret_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  board_mem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_REQ(cpuReq), .CPU_WE(cpuWe), .CPU_ADDR(cpuAddr), .CPU_WDATA(cpuWdata),
    .CPU_RDATA(cpuRdata), .CPU_STALL(cpuStall),
    .VID_REQ(vidReq), .VID_ADDR(vidAddr), .VID_GNT(vidGnt), .VID_VALID(vidValid),
    .VID_RDATA(vidRdata),
    .KEY_REQ(keyReq), .KEY_WE(keyWe), .KEY_ADDR(keyAddr), .KEY_WDATA(keyWdata),
    .KEY_GNT(keyGnt), .KEY_VALID(keyValid), .KEY_RDATA(keyRdata),
    .RAM_ADDR(ramAddr), .RAM_WDATA(ramWdata), .RAM_WE(ramWe), .RAM_RDATA(ramRdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] initVal(input int i);
    logic [7:0] b;
    b = i[7:0];
    return (b == 8'h12) ? 8'h5A : (b ^ 8'hA5);
  endfunction

  // Board RAM: registered address, read-before-write, contents loaded on the first edge.
  always @(posedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) ramMem[i] <= initVal(i);
      loaded   <= 1'b1;
      ramRdata <= 8'h00;
    end else begin
      if (ramWe) ramMem[ramAddr] <= ramWdata;
      ramRdata <= ramMem[ramAddr];
    end
  end

  function automatic vec_t v(input logic rst, input logic cReq, input logic cWe,
                             input logic [7:0] cAddr, input logic [7:0] cWd,
                             input logic vReq, input logic [7:0] vAddr,
                             input logic kReq, input logic kWe,
                             input logic [7:0] kAddr, input logic [7:0] kWd,
                             input logic [1:0] expGnt, input logic expStall);
    vec_t r;
    r.rst = rst;   r.cReq = cReq;   r.cWe = cWe;     r.cAddr = cAddr; r.cWd = cWd;
    r.vReq = vReq; r.vAddr = vAddr; r.kReq = kReq;   r.kWe = kWe;
    r.kAddr = kAddr; r.kWd = kWd;   r.expGnt = expGnt; r.expStall = expStall;
    return r;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t r);
    RESET    = r.rst;
    cpuReq   = r.cReq;  cpuWe  = r.cWe;  cpuAddr = r.cAddr; cpuWdata = r.cWd;
    vidReq   = r.vReq;  vidAddr = r.vAddr;
    keyReq   = r.kReq;  keyWe  = r.kWe;  keyAddr = r.kAddr; keyWdata = r.kWd;
  endtask

  task automatic checkOutput(input vec_t r);
    ret_t       ret;
    logic       haveRet;
    logic       expWe;
    logic [7:0] expAddr, expWd;
    haveRet = 1'b0;
    ret.who = G_NONE;
    ret.data = 8'h00;
    if (r.rst) sb.delete();
    else if (sb.size() > 0) begin
      ret = sb.pop_front();
      haveRet = 1'b1;
    end

    expWe = 1'b0; expAddr = 8'h00; expWd = 8'h00;
    case (r.expGnt)
      G_CPU: begin expWe = r.cWe; expAddr = r.cAddr; expWd = r.cWd; end
      G_VID: begin expAddr = r.vAddr; end
      G_KEY: begin expWe = r.kWe; expAddr = r.kAddr; expWd = r.kWd; end
      default: ;
    endcase

    compare("CPU_STALL", 32'(cpuStall), 32'(r.expStall));
    compare("VID_GNT",   32'(vidGnt),   32'(r.expGnt == G_VID));
    compare("KEY_GNT",   32'(keyGnt),   32'(r.expGnt == G_KEY));
    compare("RAM_WE",    32'(ramWe),    32'(expWe));
    compare("RAM_ADDR",  32'(ramAddr),  32'(expAddr));
    if (expWe) compare("RAM_WDATA", 32'(ramWdata), 32'(expWd));
    compare("VID_VALID", 32'(vidValid), 32'(haveRet && ret.who == G_VID));
    compare("KEY_VALID", 32'(keyValid), 32'(haveRet && ret.who == G_KEY));
    compare("VID_RDATA", 32'(vidRdata), (haveRet && ret.who == G_VID) ? 32'(ret.data) : 32'h0);
    compare("KEY_RDATA", 32'(keyRdata), (haveRet && ret.who == G_KEY) ? 32'(ret.data) : 32'h0);
    compare("CPU_RDATA", 32'(cpuRdata), (haveRet && ret.who == G_CPU) ? 32'(ret.data) : 32'h0);

    // Expected read data comes from the shadow RAM at issue time; writes update the shadow.
    if (r.expGnt != G_NONE) begin
      if (expWe) refMem[expAddr] = expWd;
      else sb.push_back('{who: r.expGnt, data: refMem[expAddr]});
    end
  endtask

  task automatic runCycle(input vec_t r);
    applyStimulus(r);
    @(negedge CLK);
    checkOutput(r);
    @(posedge CLK);
    #1;
    cycle++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = initVal(i);

    // reset with cpu request: everything forced idle
    vecs.push_back(v(1, 1,0,8'h00,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));
    // cpu read 0x12
    vecs.push_back(v(0, 1,0,8'h12,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_CPU,  1));
    vecs.push_back(v(0, 1,0,8'h12,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));
    // cpu write 0x3C -> 0x40, then read it back
    vecs.push_back(v(0, 1,1,8'h40,8'h3C, 0,8'h00, 0,0,8'h00,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 1,0,8'h40,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_CPU,  1));
    vecs.push_back(v(0, 1,0,8'h40,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));
    // video and keypad both held: alternate starting with video
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 1,8'h20, 1,0,8'h21,8'h00, G_VID,  0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 1,8'h22, 1,0,8'h21,8'h00, G_KEY,  0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 1,8'h24, 1,0,8'h23,8'h00, G_VID,  0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 1,8'h26, 1,0,8'h23,8'h00, G_KEY,  0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));
    // cpu writes every cycle with video held: 4 cpu grants then one video grant, twice
    vecs.push_back(v(0, 1,1,8'h50,8'h01, 1,8'h30, 0,0,8'h00,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 1,1,8'h51,8'h02, 1,8'h30, 0,0,8'h00,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 1,1,8'h52,8'h03, 1,8'h30, 0,0,8'h00,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 1,1,8'h53,8'h04, 1,8'h30, 0,0,8'h00,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 1,1,8'h54,8'h05, 1,8'h30, 0,0,8'h00,8'h00, G_VID,  1));
    vecs.push_back(v(0, 1,1,8'h54,8'h05, 1,8'h30, 0,0,8'h00,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 1,1,8'h55,8'h06, 1,8'h30, 0,0,8'h00,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 1,1,8'h56,8'h07, 1,8'h30, 0,0,8'h00,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 1,1,8'h57,8'h08, 1,8'h30, 0,0,8'h00,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 1,1,8'h58,8'h09, 1,8'h30, 0,0,8'h00,8'h00, G_VID,  1));
    vecs.push_back(v(0, 1,1,8'h58,8'h09, 0,8'h00, 0,0,8'h00,8'h00, G_CPU,  0));
    // cpu read with keypad pending: keypad granted during the cpu return cycle
    vecs.push_back(v(0, 1,0,8'h12,8'h00, 0,8'h00, 1,0,8'h40,8'h00, G_CPU,  1));
    vecs.push_back(v(0, 1,0,8'h12,8'h00, 0,8'h00, 1,0,8'h40,8'h00, G_KEY,  0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));
    // keypad write: grant only, never a valid
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 0,8'h00, 1,1,8'h41,8'h77, G_KEY,  0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));
    // all three requesting: cpu wins, then the round robin carries on
    vecs.push_back(v(0, 1,1,8'h60,8'h11, 1,8'h25, 1,0,8'h26,8'h00, G_CPU,  0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 1,8'h25, 1,0,8'h26,8'h00, G_VID,  0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 0,8'h00, 1,0,8'h26,8'h00, G_KEY,  0));
    vecs.push_back(v(0, 0,0,8'h00,8'h00, 0,8'h00, 0,0,8'h41,8'h00, G_NONE, 0));

    foreach (vecs[i]) runCycle(vecs[i]);

    // Reset in the cycle after a video grant: the return is dropped, rr_ptr goes back to video.
    runCycle(v(0, 0,0,8'h00,8'h00, 1,8'h12, 0,0,8'h00,8'h00, G_VID,  0));
    runCycle(v(1, 1,0,8'h40,8'h00, 1,8'h33, 1,0,8'h34,8'h00, G_NONE, 0));
    runCycle(v(0, 0,0,8'h00,8'h00, 1,8'h35, 1,0,8'h36,8'h00, G_VID,  0));
    runCycle(v(0, 0,0,8'h00,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));

    // Reset in the middle of a cpu read: the read restarts from C_IDLE.
    runCycle(v(0, 1,0,8'h40,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_CPU,  1));
    runCycle(v(1, 1,0,8'h40,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));
    runCycle(v(0, 1,0,8'h40,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_CPU,  1));
    runCycle(v(0, 1,0,8'h40,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));
    runCycle(v(0, 0,0,8'h00,8'h00, 0,8'h00, 0,0,8'h00,8'h00, G_NONE, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
